spi_xfer_seq: RTL and testbench

Autonomous SPI transfer sequencer that sits directly upstream of the Wishbone bus wrapper. It drives that wrapper's byte-wide register port (cs/we/addr/din/dout/rdy) to run multi-byte full-duplex transfers on one hard SB_SPI core without CPU register polling. The CPU or a stream source supplies a byte count and TX bytes, and receives RX bytes as a stream.

---
 rtl/spi_xfer_seq.sv | 192 +++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: drives a byte-wide SB_SPI register port to run multi-byte full-duplex transfers.
// Optional SPISR poll timeout: define SPI_XFER_SEQ_TIMEOUT_EN.
module spi_xfer_seq #(
  parameter logic [3:0] BASE_ADDR74 = 4'b0000,
  parameter int         LEN_W       = 8,
  parameter logic [7:0] CS_ON_VAL   = 8'hFE,
  parameter logic [7:0] CS_OFF_VAL  = 8'hFF,
  parameter int         POLL_LIMIT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             bus_cs,
  output logic             bus_we,
  output logic [7:0]       bus_addr,
  output logic [7:0]       bus_din,
  input  logic [7:0]       bus_dout,
  input  logic             bus_rdy
);

  localparam logic [3:0] REG_SR = 4'hC;
  localparam logic [3:0] REG_TX = 4'hD;
  localparam logic [3:0] REG_RX = 4'hE;
  localparam logic [3:0] REG_CS = 4'hF;
  localparam int TRDY_BIT = 4;
  localparam int RRDY_BIT = 3;

  typedef logic [$clog2(POLL_LIMIT+1)-1:0] poll_cnt_t;

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_POLL_T, S_WAIT_TX, S_WR_TX, S_POLL_R, S_RD_RX, S_CS_OFF, S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic             gap_q, gap_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       txb_q, txb_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             acc_state, acc_done, poll_flag;

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
  localparam poll_cnt_t POLL_MAX = poll_cnt_t'(POLL_LIMIT - 1);
  poll_cnt_t poll_q, poll_d;
  logic      err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // gap_q marks the mandatory idle cycle after every completed access
  assign acc_state = (state_q == S_CS_ON) || (state_q == S_POLL_T) || (state_q == S_WR_TX) ||
                     (state_q == S_POLL_R) || (state_q == S_RD_RX) || (state_q == S_CS_OFF);
  assign acc_done  = acc_state && !gap_q && bus_rdy;
  assign poll_flag = (state_q == S_POLL_T) ? bus_dout[TRDY_BIT] : bus_dout[RRDY_BIT];
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gap_q      <= 1'b0;
      rem_q      <= '0;
      txb_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
      poll_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      rem_q      <= rem_d;
      txb_q      <= txb_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
      poll_q     <= poll_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = acc_done;
    rem_d      = rem_q;
    txb_d      = txb_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
    poll_d     = poll_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            rem_d   = len;
            state_d = S_CS_ON;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_CS_ON:  if (acc_done) state_d = S_POLL_T;
      S_POLL_T, S_POLL_R: begin
        if (acc_done) begin
          if (poll_flag) begin
            state_d = (state_q == S_POLL_T) ? S_WAIT_TX : S_RD_RX;
          end
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
          else if (poll_q == POLL_MAX) begin
            err_d   = 1'b1;
            state_d = S_CS_OFF;
          end else begin
            poll_d = poll_q + poll_cnt_t'(1);
          end
`endif
        end
      end
      S_WAIT_TX: begin
        if (tx_valid) begin
          txb_d   = tx_data;
          state_d = S_WR_TX;
        end
      end
      S_WR_TX:  if (acc_done) state_d = S_POLL_R;
      S_RD_RX: begin
        if (acc_done) begin
          rx_data_d  = bus_dout;
          rx_valid_d = 1'b1;
          rem_d      = rem_q - LEN_W'(1);
          state_d    = (rem_q == LEN_W'(1)) ? S_CS_OFF : S_POLL_T;
        end
      end
      S_CS_OFF: if (acc_done) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
    // consecutive-read count restarts whenever a poll state is left
    if (state_d != state_q) poll_d = '0;
`endif
  end

  always_comb begin
    bus_we   = 1'b0;
    bus_addr = 8'h00;
    bus_din  = 8'h00;
    tx_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_CS_ON: begin
        bus_we   = 1'b1;
        bus_addr = {BASE_ADDR74, REG_CS};
        bus_din  = CS_ON_VAL;
      end
      S_POLL_T, S_POLL_R: bus_addr = {BASE_ADDR74, REG_SR};
      S_WAIT_TX:          tx_ready = 1'b1;
      S_WR_TX: begin
        bus_we   = 1'b1;
        bus_addr = {BASE_ADDR74, REG_TX};
        bus_din  = txb_q;
      end
      S_RD_RX:            bus_addr = {BASE_ADDR74, REG_RX};
      S_CS_OFF: begin
        bus_we   = 1'b1;
        bus_addr = {BASE_ADDR74, REG_CS};
        bus_din  = CS_OFF_VAL;
      end
      S_FIN:              done = 1'b1;
      default: ;
    endcase
    bus_cs = acc_state && !gap_q;
    busy   = (state_q != S_IDLE) && (state_q != S_FIN);
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq: loopback SPI bus model, randomized transfers, directed corner cases.
module tb_spi_xfer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sel, tx_valid, bus_rdy;
  logic [7:0] len, tx_data, bus_dout;

  logic       tx_ready1, rx_valid1, busy1, done1, err1, bus_cs1, bus_we1;
  logic [7:0] rx_data1, bus_addr1, bus_din1;
  logic       tx_ready2, rx_valid2, busy2, done2, err2, bus_cs2, bus_we2;
  logic [7:0] rx_data2, bus_addr2, bus_din2;

  logic       tx_ready_m, rx_valid_m, busy_m, done_m, err_m, bus_cs_m, bus_we_m;
  logic [7:0] rx_data_m, bus_addr_m, bus_din_m;

  spi_xfer_seq #(.POLL_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid & ~sel), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .done(done1), .err(err1),
    .bus_cs(bus_cs1), .bus_we(bus_we1), .bus_addr(bus_addr1), .bus_din(bus_din1),
    .bus_dout(bus_dout), .bus_rdy(bus_rdy)
  );

  spi_xfer_seq #(.BASE_ADDR74(4'b0010), .POLL_LIMIT(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid & sel), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .done(done2), .err(err2),
    .bus_cs(bus_cs2), .bus_we(bus_we2), .bus_addr(bus_addr2), .bus_din(bus_din2),
    .bus_dout(bus_dout), .bus_rdy(bus_rdy)
  );

  assign tx_ready_m = sel ? tx_ready2 : tx_ready1;
  assign rx_valid_m = sel ? rx_valid2 : rx_valid1;
  assign rx_data_m  = sel ? rx_data2  : rx_data1;
  assign busy_m     = sel ? busy2     : busy1;
  assign done_m     = sel ? done2     : done1;
  assign err_m      = sel ? err2      : err1;
  assign bus_cs_m   = sel ? bus_cs2   : bus_cs1;
  assign bus_we_m   = sel ? bus_we2   : bus_we1;
  assign bus_addr_m = sel ? bus_addr2 : bus_addr1;
  assign bus_din_m  = sel ? bus_din2  : bus_din1;

  int vectors, miscompares;
  int lat_max, gap_max, proto_err;
  bit tx_hold, force_nr;
  logic [7:0]  txq[$];
  int          delays_q[$];
  logic [16:0] log_q[$];
  logic [7:0]  rxq[$];
  logic [7:0]  preset_q[$];
  logic [7:0]  cur_tx[$];
  int          cur_dl[$];
  logic [16:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus slave: SPI core with TX looped to RX, random rdy latency, scripted not-ready poll counts
  initial begin : bus_slave
    int wcnt, lat, d_idx, nr_left;
    bit ready, rx_phase;
    logic [16:0] cap;
    logic [7:0]  loop_b;
    bus_rdy = 1'b0; bus_dout = 8'h00; wcnt = 0; lat = 1; d_idx = 0; nr_left = -1;
    rx_phase = 1'b0; loop_b = 8'h00; cap = '0; proto_err = 0; ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus_rdy = 1'b0; wcnt = 0; nr_left = -1; rx_phase = 1'b0;
      end else if (bus_rdy) begin
        bus_rdy = 1'b0;
        if (bus_cs_m) proto_err++;
      end else if (bus_cs_m) begin
        if (wcnt == 0) begin
          cap = {bus_we_m, bus_addr_m, bus_din_m};
          lat = int'($urandom_range(1, lat_max));
        end else if ({bus_we_m, bus_addr_m, bus_din_m} !== cap) begin
          proto_err++;
        end
        wcnt++;
        if (wcnt > lat) begin
          wcnt = 0;
          bus_rdy = 1'b1;
          bus_dout = 8'($urandom);
          case (bus_addr_m[3:0])
            4'hC: if (!bus_we_m) begin
              if (force_nr) ready = 1'b0;
              else begin
                if (nr_left < 0) begin
                  nr_left = (d_idx < delays_q.size()) ? delays_q[d_idx] : 0;
                  d_idx++;
                end
                if (nr_left > 0) begin ready = 1'b0; nr_left--; end
                else begin ready = 1'b1; nr_left = -1; end
              end
              bus_dout = rx_phase ? (ready ? 8'h08 : 8'h10) : (ready ? 8'h10 : 8'h08);
            end
            4'hD: if (bus_we_m) begin loop_b = bus_din_m; rx_phase = 1'b1; end
            4'hE: if (!bus_we_m) begin bus_dout = loop_b; rx_phase = 1'b0; end
            default: ;
          endcase
          log_q.push_back({bus_we_m, bus_addr_m, bus_we_m ? bus_din_m : 8'h00});
        end
      end
    end
  end

  initial begin : tx_feeder
    int tx_idx;
    bit hs;
    tx_valid = 1'b0; tx_data = 8'h00; tx_idx = 0;
    forever begin
      @(negedge clk);
      hs = tx_valid && tx_ready_m;
      @(posedge clk); #1;
      if (hs) tx_idx++;
      if (!rst && !tx_hold && tx_idx < txq.size() && $urandom_range(0, gap_max) == 0) begin
        tx_valid = 1'b1; tx_data = txq[tx_idx];
      end else begin
        tx_valid = 1'b0; tx_data = 8'($urandom);
      end
    end
  end

  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      if (rx_valid_m) rxq.push_back(rx_data_m);
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: CS on, per byte (retries+1) SPISR reads, TX write, (retries+1) SPISR reads, RX read, CS off
  task automatic build_exp(input logic [3:0] base);
    exp_q.delete();
    exp_q.push_back({1'b1, base, 4'hF, 8'hFE});
    for (int i = 0; i < cur_tx.size(); i++) begin
      for (int r = 0; r <= cur_dl[2*i]; r++) exp_q.push_back({1'b0, base, 4'hC, 8'h00});
      exp_q.push_back({1'b1, base, 4'hD, cur_tx[i]});
      for (int r = 0; r <= cur_dl[2*i+1]; r++) exp_q.push_back({1'b0, base, 4'hC, 8'h00});
      exp_q.push_back({1'b0, base, 4'hE, 8'h00});
    end
    exp_q.push_back({1'b1, base, 4'hF, 8'hFF});
  endtask

  task automatic setup_bytes(input int n, input int maxdel);
    logic [7:0] b;
    int d;
    cur_tx.delete(); cur_dl.delete();
    for (int i = 0; i < n; i++) begin
      b = (i < preset_q.size()) ? preset_q[i] : 8'($urandom);
      cur_tx.push_back(b); txq.push_back(b);
    end
    preset_q.delete();
    for (int i = 0; i < 2*n; i++) begin
      d = int'($urandom_range(0, maxdel));
      cur_dl.push_back(d); delays_q.push_back(d);
    end
  endtask

  task automatic pulse_start(input logic [7:0] l);
    @(posedge clk); #1;
    len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int cyc = 0;
    while (!done_m && cyc < bound) begin
      @(negedge clk); cyc++;
    end
    chk({tag, "_done"}, 32'(done_m), 32'd1);
  endtask

  task automatic compare_run(input string tag, input int lb, input int rb);
    chk({tag, "_nacc"}, 32'(log_q.size() - lb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (lb + i < log_q.size()) chk({tag, "_acc"}, 32'(log_q[lb+i]), 32'(exp_q[i]));
    chk({tag, "_nrx"}, 32'(rxq.size() - rb), 32'(cur_tx.size()));
    for (int i = 0; i < cur_tx.size(); i++)
      if (rb + i < rxq.size()) chk({tag, "_rx"}, 32'(rxq[rb+i]), 32'(cur_tx[i]));
    chk({tag, "_proto"}, 32'(proto_err), 32'd0);
  endtask

  task automatic run_xfer(input int n, input int maxdel, input int maxlat, input int gapmax,
                          input string tag);
    int lb, rb;
    lat_max = maxlat; gap_max = gapmax;
    lb = log_q.size(); rb = rxq.size();
    setup_bytes(n, maxdel);
    build_exp(sel ? 4'h2 : 4'h0);
    pulse_start(8'(n));
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy_m), 32'd1);
    chk({tag, "_errclr"}, 32'(err_m), 32'd0);
    wait_done(tag, 200 + n * ((4 + 2*maxdel) * (maxlat + 2) * 2 + 20 * (gapmax + 1)));
    chk({tag, "_err"}, 32'(err_m), 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 32'({done_m, busy_m}), 32'd0);
    compare_run(tag, lb, rb);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_outs"}, 32'({done_m, busy_m, bus_cs_m, bus_we_m, tx_ready_m, rx_valid_m, err_m}), 32'd0);
    chk({tag, "_bus"}, 32'({bus_addr_m, bus_din_m, rx_data_m}), 32'd0);
  endtask

  initial begin : main
    int lb, rb, cyc, ntx;
    rst = 1'b1; start = 1'b0; len = 8'h00; sel = 1'b0; tx_hold = 1'b0; force_nr = 1'b0;
    lat_max = 1; gap_max = 0; vectors = 0; miscompares = 0;
    repeat (3) @(negedge clk);
    check_idle("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_rel");

    // zero-length request: done one cycle later, never busy, no bus access
    lb = log_q.size();
    pulse_start(8'd0);
    @(negedge clk);
    chk("len0_done", 32'(done_m), 32'd1);
    chk("len0_busy_cs", 32'({busy_m, bus_cs_m}), 32'd0);
    @(negedge clk);
    chk("len0_after", 32'({done_m, busy_m, bus_cs_m}), 32'd0);
    chk("len0_nacc", 32'(log_q.size() - lb), 32'd0);

    preset_q.push_back(8'hA5); preset_q.push_back(8'h3C);
    run_xfer(2, 0, 1, 0, "dir2");

    for (int k = 0; k < 6; k++) run_xfer(int'($urandom_range(1, 6)), 2, 3, 2, "rnd");
    run_xfer(255, 0, 1, 0, "max255");

    // second core at BASE_ADDR74 = 2
    sel = 1'b1;
    lb = log_q.size();
    run_xfer(1, 1, 2, 1, "base2");
    for (int i = lb; i < log_q.size(); i++)
      chk("base2_addr", 32'(log_q[i][15:8] >= 8'h2C && log_q[i][15:8] <= 8'h2F), 32'd1);
    sel = 1'b0;

    // TX stall in WAIT_TX with an ignored start pulse
    lat_max = 1; gap_max = 0; tx_hold = 1'b1;
    lb = log_q.size(); rb = rxq.size();
    preset_q.push_back(8'h5A);
    setup_bytes(1, 0);
    build_exp(4'h0);
    pulse_start(8'd1);
    cyc = 0;
    while (!tx_ready_m && cyc < 100) begin @(negedge clk); cyc++; end
    chk("stall_reach", 32'(tx_ready_m), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_rdy", 32'(tx_ready_m), 32'd1);
      start = (i == 10); len = (i == 10) ? 8'd7 : 8'd1;
    end
    start = 1'b0;
    ntx = 0;
    for (int i = lb; i < log_q.size(); i++) if (log_q[i][16] && log_q[i][11:8] == 4'hD) ntx++;
    chk("stall_notx", 32'(ntx), 32'd0);
    tx_hold = 1'b0;
    wait_done("stall", 300);
    @(negedge clk);
    compare_run("stall", lb, rb);

    // asynchronous reset while the SPITXDR write is on the bus
    lb = log_q.size();
    setup_bytes(1, 0);
    pulse_start(8'd1);
    cyc = 0;
    while (!(bus_cs_m && bus_we_m && bus_addr_m[3:0] == 4'hD) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("arst_found", 32'(bus_cs_m && bus_we_m), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_outs", 32'({bus_cs_m, busy_m, done_m, rx_valid_m, tx_ready_m}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", 32'({bus_cs_m, busy_m}), 32'd0);
    run_xfer(1, 0, 1, 0, "post_rst");

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
    // TRDY never set: 4 SPISR reads, CS off, done with err
    force_nr = 1'b1;
    lb = log_q.size(); rb = rxq.size();
    cur_tx.delete(); cur_dl.delete();
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h0F, 8'hFE});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h0C, 8'h00});
    exp_q.push_back({1'b1, 8'h0F, 8'hFF});
    pulse_start(8'd3);
    wait_done("tmo", 300);
    chk("tmo_err", 32'(err_m), 32'd1);
    @(negedge clk);
    chk("tmo_err_sticky", 32'(err_m), 32'd1);
    compare_run("tmo", lb, rb);
    force_nr = 1'b0;
    run_xfer(1, 0, 1, 0, "tmo_clr");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
